// File: rtl/media_quadrantes.sv
// Averages a centred 2^WIN_LOG2 x 2^WIN_LOG2 window inside each 3x3 facelet cell of an RGB565
// frame and writes the 9 means to the facelet RAM. Define MEDIA_QUADRANTES_DB_EN for debug ports.
module media_quadrantes #(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int X0       = 40,
  parameter int Y0       = 0,
  parameter int CELL     = 80,
  parameter int WIN_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        frame_inicio,
  input  logic        pixel_valido,
  input  logic [15:0] pixel_dado,
  output logic        we_media,
  output logic [3:0]  endereco,
  output logic [4:0]  media_r,
  output logic [5:0]  media_g,
  output logic [4:0]  media_b,
  output logic        ocupado,
  output logic        pronto
`ifdef MEDIA_QUADRANTES_DB_EN
  ,
  output logic [3:0]  db_estado,
  output logic [16:0] db_pixels
`endif
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam int OFF = (CELL - WIN) / 2;
  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H + 1);
  localparam int AR  = 5 + 2 * WIN_LOG2;
  localparam int AG  = 6 + 2 * WIN_LOG2;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  typedef enum logic [2:0] {
    INICIAL      = 3'd0,
    ESPERA_FRAME = 3'd1,
    ACUMULA      = 3'd2,
    ESCREVE      = 3'd3,
    FIM          = 3'd4
  } estado_t;

  estado_t       estado_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          we_q, ocupado_q, pronto_q;
  logic [3:0]    end_q;
  logic [4:0]    r_q, b_q;
  logic [5:0]    g_q;

  logic [AR-1:0] acc_r_q [9];
  logic [AR-1:0] acc_r_d [9];
  logic [AG-1:0] acc_g_q [9];
  logic [AG-1:0] acc_g_d [9];
  logic [AR-1:0] acc_b_q [9];
  logic [AR-1:0] acc_b_d [9];

  logic [8:0] hit;
  logic       limpa, aceita;
  logic [3:0] sel;
  logic [4:0] m_r, m_b;
  logic [5:0] m_g;

  // Division by the window area is a plain shift; the top bits are the mean.
  function automatic logic [4:0] media5(input logic [AR-1:0] a);
    return a[2*WIN_LOG2 +: 5];
  endfunction

  function automatic logic [5:0] media6(input logic [AG-1:0] a);
    return a[2*WIN_LOG2 +: 6];
  endfunction

  for (genvar gl = 0; gl < 3; gl++) begin : g_lin
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      localparam int WX = X0 + gc * CELL + OFF;
      localparam int WY = Y0 + gl * CELL + OFF;
      assign hit[gl*3+gc] = (int'(x_q) >= WX) && (int'(x_q) < WX + WIN) &&
                            (int'(y_q) >= WY) && (int'(y_q) < WY + WIN);
    end
  end

  // frame_inicio wins over a coincident pixel; both only matter while waiting or accumulating.
  assign limpa  = frame_inicio && (estado_q == ESPERA_FRAME || estado_q == ACUMULA);
  assign aceita = pixel_valido && !frame_inicio && (estado_q == ACUMULA);

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      acc_r_d[k] = acc_r_q[k];
      acc_g_d[k] = acc_g_q[k];
      acc_b_d[k] = acc_b_q[k];
      if (limpa) begin
        acc_r_d[k] = '0;
        acc_g_d[k] = '0;
        acc_b_d[k] = '0;
      end else if (aceita && hit[k]) begin
        acc_r_d[k] = acc_r_q[k] + AR'(pixel_dado[15:11]);
        acc_g_d[k] = acc_g_q[k] + AG'(pixel_dado[10:5]);
        acc_b_d[k] = acc_b_q[k] + AR'(pixel_dado[4:0]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) begin
        acc_r_q[k] <= '0;
        acc_g_q[k] <= '0;
        acc_b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        acc_r_q[k] <= acc_r_d[k];
        acc_g_q[k] <= acc_g_d[k];
        acc_b_q[k] <= acc_b_d[k];
      end
    end
  end

  // Read from next-state sums so a window pixel on the final clock still lands in address 0.
  always_comb begin
    sel = (estado_q == ESCREVE) ? end_q + 4'd1 : 4'd0;
    m_r = '0;
    m_g = '0;
    m_b = '0;
    for (int k = 0; k < 9; k++) begin
      if (sel == 4'(k)) begin
        m_r = media5(acc_r_d[k]);
        m_g = media6(acc_g_d[k]);
        m_b = media5(acc_b_d[k]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      x_q       <= '0;
      y_q       <= '0;
      we_q      <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      end_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      case (estado_q)
        INICIAL: begin
          if (iniciar) begin
            estado_q  <= ESPERA_FRAME;
            ocupado_q <= 1'b1;
          end
        end
        ESPERA_FRAME: begin
          if (frame_inicio) begin
            estado_q <= ACUMULA;
            x_q      <= '0;
            y_q      <= '0;
          end
        end
        ACUMULA: begin
          if (frame_inicio) begin
            x_q <= '0;
            y_q <= '0;
          end else if (pixel_valido) begin
            if (x_q == X_MAX) begin
              x_q <= '0;
              if (y_q == Y_MAX) begin
                y_q      <= '0;
                estado_q <= ESCREVE;
                we_q     <= 1'b1;
                end_q    <= '0;
                r_q      <= m_r;
                g_q      <= m_g;
                b_q      <= m_b;
              end else begin
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        ESCREVE: begin
          if (end_q == 4'd8) begin
            estado_q <= FIM;
            we_q     <= 1'b0;
            pronto_q <= 1'b1;
            end_q    <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
          end else begin
            end_q <= end_q + 4'd1;
            r_q   <= m_r;
            g_q   <= m_g;
            b_q   <= m_b;
          end
        end
        FIM: begin
          estado_q  <= INICIAL;
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  assign we_media = we_q;
  assign endereco = end_q;
  assign media_r  = r_q;
  assign media_g  = g_q;
  assign media_b  = b_q;
  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;

`ifdef MEDIA_QUADRANTES_DB_EN
  logic [16:0] db_pixels_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_pixels_q <= '0;
    end else if (limpa) begin
      db_pixels_q <= '0;
    end else if (aceita && db_pixels_q != '1) begin
      db_pixels_q <= db_pixels_q + 17'd1;
    end
  end

  assign db_estado = {1'b0, estado_q};
  assign db_pixels = db_pixels_q;
`endif

endmodule

// File: tb/tb_media_quadrantes.sv
// Directed bench for media_quadrantes on a reduced 60x56 frame with 16x16 windows in 18-pixel cells.
module tb_media_quadrantes;

  localparam int W    = 60;
  localparam int H    = 56;
  localparam int X0   = 4;
  localparam int Y0   = 2;
  localparam int CELL = 18;
  localparam int WL   = 4;
  localparam int WIN  = 16;
  localparam int OFF  = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic        frame_inicio = 1'b0;
  logic        pixel_valido = 1'b0;
  logic [15:0] pixel_dado = 16'h0000;
  logic        we_media;
  logic [3:0]  endereco;
  logic [4:0]  media_r;
  logic [5:0]  media_g;
  logic [4:0]  media_b;
  logic        ocupado;
  logic        pronto;

  int checks = 0;
  int failures = 0;
  int nwr, npr, pr_n;
  int got_r [9];
  int got_g [9];
  int got_b [9];

  always #5 clock = ~clock;

  media_quadrantes #(
    .IMG_W(W), .IMG_H(H), .X0(X0), .Y0(Y0), .CELL(CELL), .WIN_LOG2(WL)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .frame_inicio(frame_inicio),
    .pixel_valido(pixel_valido), .pixel_dado(pixel_dado), .we_media(we_media),
    .endereco(endereco), .media_r(media_r), .media_g(media_g), .media_b(media_b),
    .ocupado(ocupado), .pronto(pronto)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int win_of(input int x, input int y);
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 3; c++)
        if (x >= X0 + c*CELL + OFF && x < X0 + c*CELL + OFF + WIN &&
            y >= Y0 + l*CELL + OFF && y < Y0 + l*CELL + OFF + WIN)
          return l*3 + c;
    return -1;
  endfunction

  function automatic logic [15:0] pix(input int t, input int x, input int y);
    int k;
    k = win_of(x, y);
    case (t)
      1: return 16'hF800;
      2: if (k < 0) return 16'hFFFF; else return {5'(k), 6'(2*k), 5'(31-k)};
      3: if (k < 0) return 16'hFFFF; else return ((x + y) % 2 == 1) ? 16'h07E0 : 16'h0000;
      default: return 16'h001F;
    endcase
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_iniciar;
    iniciar = 1'b1;
    step;
    iniciar = 1'b0;
  endtask

  task automatic frame_start(input logic with_pixel);
    frame_inicio = 1'b1;
    pixel_valido = with_pixel;
    pixel_dado   = 16'hFFFF;
    step;
    frame_inicio = 1'b0;
    pixel_valido = 1'b0;
  endtask

  task automatic send_pixels(input int t, input int ya, input int yb, input int maxgap, input int ini_at);
    for (int y = ya; y < yb; y++) begin
      for (int x = 0; x < W; x++) begin
        repeat ($urandom_range(0, maxgap)) step;
        pixel_valido = 1'b1;
        pixel_dado   = pix(t, x, y);
        iniciar      = (y*W + x == ini_at);
        step;
        pixel_valido = 1'b0;
        iniciar      = 1'b0;
      end
    end
  endtask

  // Called #1 after the edge that accepted the last pixel; n counts cycles from there.
  task automatic collect(input int abort_at);
    nwr = 0; npr = 0; pr_n = 0;
    for (int k = 0; k < 9; k++) begin
      got_r[k] = -1; got_g[k] = -1; got_b[k] = -1;
    end
    for (int n = 1; n <= 14; n++) begin
      if (pronto) begin
        npr++;
        if (pr_n == 0) pr_n = n;
      end
      if (we_media) begin
        if (abort_at == int'(endereco)) begin
          reset = 1'b0;
          #1;
          chk("abort_we", int'(we_media), 0);
          chk("abort_addr", int'(endereco), 0);
          chk("abort_r", int'(media_r), 0);
          chk("abort_g", int'(media_g), 0);
          chk("abort_b", int'(media_b), 0);
          chk("abort_ocupado", int'(ocupado), 0);
          chk("abort_pronto", int'(pronto), 0);
          step;
          reset = 1'b1;
          for (int m = 0; m < 15; m++) begin
            if (pronto || we_media) npr++;
            step;
          end
          chk("abort_no_activity", npr, 0);
          return;
        end
        chk("addr_seq", int'(endereco), nwr);
        if (nwr < 9) begin
          got_r[nwr] = int'(media_r);
          got_g[nwr] = int'(media_g);
          got_b[nwr] = int'(media_b);
        end
        nwr++;
      end
      step;
    end
    chk("write_count", nwr, 9);
    chk("pronto_cycle", pr_n, 10);
    chk("pronto_count", npr, 1);
  endtask

  task automatic chk_vals(input string tag, input int t);
    int er, eg, eb;
    for (int k = 0; k < 9; k++) begin
      case (t)
        1: begin er = 31; eg = 0;     eb = 0;      end
        2: begin er = k;  eg = 2 * k; eb = 31 - k; end
        3: begin er = 0;  eg = 31;    eb = 0;      end
        default: begin er = 0; eg = 0; eb = 31; end
      endcase
      chk($sformatf("%s_r%0d", tag, k), got_r[k], er);
      chk($sformatf("%s_g%0d", tag, k), got_g[k], eg);
      chk($sformatf("%s_b%0d", tag, k), got_b[k], eb);
    end
  endtask

  task automatic run(input string tag, input int t, input int maxgap, input int ini_at);
    pulse_iniciar;
    chk({tag, "_ocupado"}, int'(ocupado), 1);
    frame_start(1'b0);
    send_pixels(t, 0, H, maxgap, ini_at);
    collect(-1);
    chk_vals(tag, t);
  endtask

  initial begin
    int act;
    #12;
    chk("rst_we", int'(we_media), 0);
    chk("rst_addr", int'(endereco), 0);
    chk("rst_r", int'(media_r), 0);
    chk("rst_g", int'(media_g), 0);
    chk("rst_b", int'(media_b), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step;

    run("uniform_red", 1, 0, -1);
    run("cells", 2, 0, -1);
    run("half_green", 3, 0, -1);
    run("gaps", 2, 5, 1000);

    repeat (3) step;
    chk("idle_after_gaps", int'(ocupado), 0);
    frame_start(1'b1);
    act = 0;
    for (int m = 0; m < 20; m++) begin
      if (we_media || pronto || ocupado) act++;
      step;
    end
    chk("no_second_pass", act, 0);

    pulse_iniciar;
    frame_start(1'b0);
    send_pixels(1, 0, 30, 0, -1);
    frame_start(1'b1);
    send_pixels(5, 0, H, 0, -1);
    collect(-1);
    chk_vals("restart", 5);

    pulse_iniciar;
    frame_start(1'b0);
    send_pixels(1, 0, H, 0, -1);
    collect(4);
    run("after_abort", 5, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
